// File: rtl/keypad_pkg.sv
// Shared types, key layout and row-decoding helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Key legend indexed by {row_idx, col_idx}; row 0 is the top row.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // True when exactly one of the four active-low row lines is pulled low.
  function automatic logic onehot_low(input logic [3:0] v);
    logic [3:0] z;
    z = ~v;
    return (z != 4'b0000) && ((z & (z - 4'd1)) == 4'b0000);
  endfunction

  // Index of the low bit; only meaningful when onehot_low() holds.
  function automatic logic [1:0] onehot_low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational row/column to hex-nibble decoder for the 4x4 keypad.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [1:0] col_idx,
  output logic [3:0] code
);

  assign code = KEYMAP[{row_idx, col_idx}];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, press/release debounce,
// one-cycle strobe per accepted key and a two-digit history for the display.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT     = 24_000,
  parameter int DEBOUNCE_COUNT = 960_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int MAX_COUNT = (SCAN_COUNT > DEBOUNCE_COUNT) ? SCAN_COUNT : DEBOUNCE_COUNT;
  localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_COUNT - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [3:0]       rows_p0;
  logic [3:0]       rows_s;
  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [1:0]       col_next;
  logic [3:0]       pattern;
  logic [3:0]       code;

  assign col_next = col_idx + 2'd1;

  keypad_decode u_decode (
    .row_idx (row_idx),
    .col_idx (col_idx),
    .code    (code)
  );

  // Two-flop synchronizer for the asynchronous row lines; idles at "no key".
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_p0 <= 4'hF;
      rows_s  <= 4'hF;
    end else begin
      rows_p0 <= rows;
      rows_s  <= rows_p0;
    end
  end

  // Scan/debounce FSM; the column drive and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      counter   <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      pattern   <= 4'hF;
      cols      <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (counter == SCAN_LAST) begin
            counter <= '0;
            if (onehot_low(rows_s)) begin
              row_idx <= onehot_low_idx(rows_s);
              pattern <= rows_s;
              state   <= DEBOUNCE;
            end else begin
              // Idle column or a multi-key press: move on to the next column.
              col_idx <= col_next;
              cols    <= ~(4'b0001 << col_next);
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        DEBOUNCE: begin
          if (rows_s != pattern) begin
            counter <= '0;
            col_idx <= col_next;
            cols    <= ~(4'b0001 << col_next);
            state   <= SCAN;
          end else if (counter == DEB_LAST) begin
            key_valid <= 1'b1;
            key_code  <= code;
            digit_old <= digit_new;
            digit_new <= code;
            counter   <= '0;
            state     <= HELD;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        HELD: begin
          if (rows_s[row_idx]) begin
            counter <= '0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          if (!rows_s[row_idx]) begin
            // Contact bounce on release: the key is still considered held.
            counter <= '0;
            state   <= HELD;
          end else if (counter == DEB_LAST) begin
            counter <= '0;
            col_idx <= col_next;
            cols    <= ~(4'b0001 << col_next);
            state   <= SCAN;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// DUT's columns, and a procedural timeline model predicts every output cycle.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  bit [15:0]  pressed = '0;
  int         total = 0;
  int         bad = 0;
  bit         chk_en = 1'b0;
  int         pulses = 0;
  int         p0;

  // Reference model outputs.
  logic [3:0] m_cols = 4'b1110;
  logic       m_valid = 1'b0;
  logic [3:0] m_code = 4'h0;
  logic [3:0] m_new = 4'h0;
  logic [3:0] m_old = 4'h0;
  int         m_phase = 0;  // 0 scanning, 1 debouncing, 2 held, 3 releasing
  logic [3:0] h1 = 4'hF;
  logic [3:0] h2 = 4'hF;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_COUNT(SC), .DEBOUNCE_COUNT(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  // Physical keypad: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
  end

  function automatic logic [3:0] key_of(input int r, input int c);
    string layout;
    byte   ch;
    layout = "123A456B789CE0FD";
    ch = layout[r*4+c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cols", cols, m_cols);
      chk("key_valid", key_valid, m_valid);
      chk("key_code", key_code, m_code);
      chk("digit_new", digit_new, m_new);
      chk("digit_old", digit_old, m_old);
      if (key_valid === 1'b1) pulses++;
    end
  end

  // One clock of model time: returns the synchronized rows seen at this edge.
  task automatic mtick(output logic [3:0] rs, output bit aborted);
    logic [3:0] r;
    logic       rst;
    @(negedge clk);
    r = rows;
    rst = reset;
    @(posedge clk);
    m_valid = 1'b0;
    aborted = 1'b0;
    rs = h2;
    if (rst !== 1'b1) begin
      aborted = 1'b1;
      h1 = 4'hF; h2 = 4'hF;
      m_cols = 4'b1110; m_code = 4'h0; m_new = 4'h0; m_old = 4'h0;
      m_phase = 0;
    end else begin
      h2 = h1;
      h1 = r;
    end
  endtask

  task automatic set_col(input int col);
    m_cols = 4'hF;
    m_cols[col] = 1'b0;
  endtask

  // Timeline model: returns whenever a reset edge is seen.
  task automatic run_model();
    logic [3:0] rs, pat;
    bit ab, ok, done;
    int col, row, n;
    col = 0;
    forever begin
      m_phase = 0;
      set_col(col);
      for (int i = 0; i < SC; i++) begin
        mtick(rs, ab);
        if (ab) return;
      end
      if ($countones(~rs) != 1) begin
        col = (col + 1) % 4;
        continue;
      end
      pat = rs;
      row = 0;
      for (int r = 0; r < 4; r++) if (!rs[r]) row = r;
      m_phase = 1;
      ok = 1'b1;
      for (int i = 0; i < DC; i++) begin
        mtick(rs, ab);
        if (ab) return;
        if (rs != pat) begin ok = 1'b0; break; end
      end
      if (!ok) begin
        col = (col + 1) % 4;
        continue;
      end
      m_valid = 1'b1;
      m_old = m_new;
      m_new = key_of(row, col);
      m_code = m_new;
      done = 1'b0;
      while (!done) begin
        m_phase = 2;
        do begin
          mtick(rs, ab);
          if (ab) return;
        end while (rs[row] == 1'b0);
        m_phase = 3;
        n = 0;
        forever begin
          mtick(rs, ab);
          if (ab) return;
          if (rs[row] == 1'b0) break;
          n++;
          if (n == DC) begin done = 1'b1; break; end
        end
      end
      col = (col + 1) % 4;
    end
  endtask

  initial begin
    forever run_model();
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int p, input int budget, input string tag);
    int k;
    k = 0;
    while (m_phase != p && k < budget) begin
      wait_cyc(1);
      k++;
    end
    chk(tag, m_phase, p);
  endtask

  task automatic press(input int r, input int c, input bit v);
    pressed[r*4+c] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2;
    reset = 1'b0;
    pressed = '0;
    wait_cyc(3);
    chk_en = 1'b1;
    chk("rst_cols", cols, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_new", digit_new, 4'h0);
    chk("rst_old", digit_old, 4'h0);
    reset = 1'b1;
    wait_cyc(24);

    // Key 5 held stable.
    p0 = pulses;
    press(1, 1, 1'b1);
    wait_cyc(60);
    chk("n_5", pulses - p0, 1);
    chk("code_5", key_code, 4'h5);
    chk("new_5", digit_new, 4'h5);
    chk("old_5", digit_old, 4'h0);
    chk("cols_held5", cols, 4'b1101);
    press(1, 1, 1'b0);
    wait_cyc(40);

    // 7 then F.
    p0 = pulses;
    press(2, 0, 1'b1); wait_cyc(60); press(2, 0, 1'b0); wait_cyc(40);
    press(3, 2, 1'b1); wait_cyc(60); press(3, 2, 1'b0); wait_cyc(40);
    chk("n_7F", pulses - p0, 2);
    chk("new_F", digit_new, 4'hF);
    chk("old_7", digit_old, 4'h7);

    // Press bounce on key 3 during debounce.
    p0 = pulses;
    press(0, 2, 1'b1);
    wait_phase(1, 60, "reach_deb3");
    wait_cyc(2);
    press(0, 2, 1'b0); wait_cyc(3); press(0, 2, 1'b1);
    wait_phase(0, 20, "abort_deb3");
    chk("n_bounce3", pulses - p0, 0);
    wait_cyc(60);
    chk("n_3", pulses - p0, 1);
    chk("code_3", key_code, 4'h3);
    press(0, 2, 1'b0);
    wait_cyc(40);

    // Release bounce on key 9.
    p0 = pulses;
    press(2, 2, 1'b1);
    wait_phase(2, 80, "reach_held9");
    wait_cyc(3);
    press(2, 2, 1'b0); wait_cyc(3); press(2, 2, 1'b1);
    wait_cyc(30);
    chk("phase_held9", m_phase, 2);
    press(2, 2, 1'b0);
    wait_cyc(40);
    chk("n_9", pulses - p0, 1);
    chk("code_9", key_code, 4'h9);

    // Two keys in column 0.
    p0 = pulses;
    press(0, 0, 1'b1); press(1, 0, 1'b1);
    wait_cyc(50);
    chk("n_multi", pulses - p0, 0);
    press(0, 0, 1'b0); press(1, 0, 1'b0);
    wait_cyc(20);

    // Reset during debounce of key 6.
    p0 = pulses;
    press(1, 2, 1'b1);
    wait_phase(1, 60, "reach_deb6");
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    chk("mr_cols", cols, 4'b1110);
    chk("mr_valid", key_valid, 1'b0);
    chk("mr_code", key_code, 4'h0);
    chk("mr_new", digit_new, 4'h0);
    chk("mr_old", digit_old, 4'h0);
    chk("n_mr", pulses - p0, 0);
    reset = 1'b1;
    wait_cyc(60);
    chk("n_6", pulses - p0, 1);
    chk("code_6", key_code, 4'h6);
    chk("old_6", digit_old, 4'h0);
    press(1, 2, 1'b0);
    wait_cyc(40);

    // Random presses, multi-key presses and chatter.
    for (int it = 0; it < 40; it++) begin
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0: begin
          pressed[k1] = 1'b1;
          wait_cyc($urandom_range(1, 60));
        end
        1: begin
          pressed[k1] = 1'b1;
          pressed[k2] = 1'b1;
          wait_cyc($urandom_range(5, 50));
        end
        default: begin
          pressed[k1] = 1'b1;
          for (int j = 0; j < 6; j++) begin
            wait_cyc($urandom_range(1, 6));
            pressed[k1] = ~pressed[k1];
          end
          pressed[k1] = 1'b1;
          wait_cyc($urandom_range(20, 60));
        end
      endcase
      pressed = '0;
      wait_cyc($urandom_range(1, 40));
    end
    wait_cyc(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad: drives one column low at a time, samples the rows, debounces presses and releases, and decodes the key to a hex nibble.
- Emits a one-cycle strobe per accepted press.
- Keeps the two most recent digits (newest and previous) for the two-digit seven-segment multiplexer.
- Sits between the keypad pins and the display mux, and replaces the switch inputs as the digit source.

Parameters:
- SCAN_COUNT, 24_000: cycles each column is driven before the rows are sampled (0.5 ms at 48 MHz).
- DEBOUNCE_COUNT, 960_000: cycles a press or release must stay stable to be accepted (20 ms at 48 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- rows  input  4  keypad row lines; active-low, pulled up externally; asynchronous to clk.
- cols  output  4  keypad column drives; the active column is 0, all others are 1.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_code  output  4  hex code of the last accepted key; holds its value between presses.
- digit_new  output  4  most recent accepted digit; feeds the right display.
- digit_old  output  4  previous accepted digit; feeds the left display.

Behaviour:
- Reset (reset==0 at a clk edge), all of these apply on the same edge:
  - state=SCAN, col_idx=0, counter=0.
  - cols=4'b1110, key_valid=0, key_code=0, digit_new=0, digit_old=0.
  - Synchronizer flops are set to 4'b1111.
- Reset mid-press: the press is abandoned. After release of reset, a key still held is detected fresh and debounced fully.
- rows passes through a 2-flop synchronizer to give rows_s, which adds 2 cycles of latency. All decisions use rows_s.
- cols = ~(4'b0001 << col_idx), driven from a register (glitch-free).
- Key map, rows 0..3 top to bottom, columns 0..3 left to right:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - counter increments every cycle.
  - At counter==SCAN_COUNT-1, counter resets to 0 and rows_s is examined.
  - If exactly one bit of rows_s is 0: capture row_idx, go to DEBOUNCE, keep col_idx.
  - If zero or more than one bit is 0: col_idx advances, wrapping 3->0. Multi-key presses are ignored.
- DEBOUNCE:
  - The column stays driven and counter increments.
  - If rows_s differs from the captured one-low pattern on any cycle: counter=0, col_idx advances, go to SCAN. No strobe.
  - At counter==DEBOUNCE_COUNT-1 with the pattern still stable, on the same edge:
    - key_valid=1 for exactly one cycle;
    - key_code=map(row,col);
    - digit_old<=digit_new and digit_new<=map(row,col);
    - counter=0; go to HELD.
- HELD:
  - The column stays driven and no further strobes are issued, even if other keys in the same column are pressed.
  - When the captured row bit of rows_s goes to 1: counter=0, go to RELEASE.
- RELEASE:
  - counter increments.
  - If the captured row bit goes back to 0 before the count completes: return to HELD with no new strobe (contact bounce).
  - At counter==DEBOUNCE_COUNT-1 with the bit still 1: counter=0, col_idx advances, go to SCAN.
- Presses in other columns during DEBOUNCE, HELD or RELEASE are invisible, because only one column is driven. They are picked up by a later scan if still held.
- Counter width: $clog2(max(SCAN_COUNT,DEBOUNCE_COUNT)). The counter never exceeds its terminal value.
- Latency from a stable press to key_valid: at most 2 + (4*SCAN_COUNT) + DEBOUNCE_COUNT cycles.

Decomposition:
- Package keypad_pkg contains:
  - the state_t enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - the 16-entry KEYMAP constant, indexed {row_idx, col_idx};
  - helper function onehot_low_idx.
- Sub-module keypad_decode: combinational row_idx/col_idx -> hex nibble using KEYMAP. It is unit-tested separately.

Test Plan (SCAN_COUNT=4, DEBOUNCE_COUNT=8):
- Reset with rows=4'b1111: cols=1110 and all outputs 0. cols then cycles 1110->1101->1011->0111->1110, holding each pattern 4 cycles.
- Press "5" (row1 low while col1 is driven), held stable: exactly one key_valid pulse, key_code=5, digit_new=5, digit_old=0. cols stays 1101 until release has been debounced.
- Press "7", release, then press "F": key_valid pulses twice, ending with digit_new=F and digit_old=7.
- Bounce row0 on col2 ("3") for 3 cycles during DEBOUNCE: no key_valid, scan resumes. A stable press afterwards gives key_code=3.
- Release bounce in RELEASE (row high 3 cycles, then low again): returns to HELD, with no second pulse for the same key.
- Rows 4'b1100 during col0 (two keys pressed): no strobe, scan continues. Assert reset mid-DEBOUNCE: outputs return to their reset values and no strobe is issued.
